// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand/result register bank.
// Covers default sizing, the LOAD/RUN state encoding and the address-width helper.
package alu_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/alu_reg_bank_if.sv
// Bus bundle between the ALU sequencer (master) and the register bank (slave).
// All strobes (load_valid, rd_en, wr_en) are single-cycle and have no back-pressure:
// the bank accepts a strobe at the rising edge it is seen, provided the current
// state honours it. rd_valid is a one-cycle response to the previous edge's rd_en.
interface alu_reg_bank_if
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int AW = addr_width(DEPTH);

    logic               load_valid;
    logic [AW-1:0]      load_addr;
    logic [WIDTH-1:0]   load_data;
    logic               load_last;
    logic               rd_en;
    logic [AW-1:0]      rd_addr_a;
    logic [AW-1:0]      rd_addr_b;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               rd_valid;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [2*WIDTH-1:0] wr_result;
    logic               running;
    logic [0:0]         state_dbg;

    modport master (
        output load_valid, load_addr, load_data, load_last,
        output rd_en, rd_addr_a, rd_addr_b,
        output wr_en, wr_addr, wr_result,
        input  a, b, rd_valid, running, state_dbg
    );

    modport slave (
        input  load_valid, load_addr, load_data, load_last,
        input  rd_en, rd_addr_a, rd_addr_b,
        input  wr_en, wr_addr, wr_result,
        output a, b, rd_valid, running, state_dbg
    );

endinterface

// File: rtl/rf_read_port.sv
// One registered read port: array mux with write-first bypass of the hi/lo
// halves being written in the same cycle.
module rf_read_port
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = addr_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rd_fire,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] mem [DEPTH],
    input  logic             wr_fire,
    input  logic [AW-1:0]    wr_addr_hi,
    input  logic [AW-1:0]    wr_addr_lo,
    input  logic [WIDTH-1:0] wr_hi,
    input  logic [WIDTH-1:0] wr_lo,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] next_q;

    // hi and lo addresses never coincide, so compare order does not matter.
    always_comb begin
        next_q = mem[addr];
        if (wr_fire && (addr == wr_addr_hi)) begin
            next_q = wr_hi;
        end else if (wr_fire && (addr == wr_addr_lo)) begin
            next_q = wr_lo;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (rd_fire) begin
            q <= next_q;
        end
    end

endmodule

// File: rtl/alu_reg_bank.sv
// ALU operand/result register bank: preloaded in LOAD, then read on two ports
// and written back with double-width results in RUN.
module alu_reg_bank
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic           clock,
    input logic           reset,
    alu_reg_bank_if.slave bus
);

    localparam int AW = addr_width(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [0:0]       state;
    logic             rd_valid_q;
    logic             in_run;
    logic             rd_fire;
    logic             wr_fire;
    logic [AW-1:0]    wr_addr_hi;
    logic [AW-1:0]    wr_addr_lo;
    logic [WIDTH-1:0] wr_hi;
    logic [WIDTH-1:0] wr_lo;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    assign in_run     = (state == ST_RUN);
    assign rd_fire    = in_run && bus.rd_en;
    assign wr_fire    = in_run && bus.wr_en;
    assign wr_addr_hi = bus.wr_addr;
    // DEPTH is a power of two, so the AW-bit increment wraps to 0 by itself.
    assign wr_addr_lo = bus.wr_addr + AW'(1);
    assign wr_hi      = bus.wr_result[2*WIDTH-1:WIDTH];
    assign wr_lo      = bus.wr_result[WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            state      <= ST_LOAD;
            rd_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (bus.load_valid) begin
                        regs[bus.load_addr] <= bus.load_data;
                        if (bus.load_last) begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    if (bus.wr_en) begin
                        regs[wr_addr_hi] <= wr_hi;
                        regs[wr_addr_lo] <= wr_lo;
                    end
                    rd_valid_q <= bus.rd_en;
                end
            endcase
        end
    end

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_a (
        .clock      (clock),
        .reset      (reset),
        .rd_fire    (rd_fire),
        .addr       (bus.rd_addr_a),
        .mem        (regs),
        .wr_fire    (wr_fire),
        .wr_addr_hi (wr_addr_hi),
        .wr_addr_lo (wr_addr_lo),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .q          (a_q)
    );

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_b (
        .clock      (clock),
        .reset      (reset),
        .rd_fire    (rd_fire),
        .addr       (bus.rd_addr_b),
        .mem        (regs),
        .wr_fire    (wr_fire),
        .wr_addr_hi (wr_addr_hi),
        .wr_addr_lo (wr_addr_lo),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .q          (b_q)
    );

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.running   = in_run;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_alu_reg_bank.sv
// Bench for alu_reg_bank: directed scenarios plus random traffic, checked every
// cycle against an array-level model of the register bank.
module tb_alu_reg_bank;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AW = 3;

    logic clock;
    logic reset;

    alu_reg_bank_if #(.WIDTH(W), .DEPTH(D)) bus ();

    alu_reg_bank #(.WIDTH(W), .DEPTH(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // behavioural model
    logic [W-1:0] m_regs [D];
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic         m_rdv;
    logic         m_run;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [W-1:0] nxt [D];
        if (reset) begin
            for (int i = 0; i < D; i++) m_regs[i] = '0;
            m_a = '0; m_b = '0; m_rdv = 1'b0; m_run = 1'b0;
        end else if (!m_run) begin
            if (bus.load_valid) begin
                m_regs[bus.load_addr] = bus.load_data;
                if (bus.load_last) m_run = 1'b1;
            end
        end else begin
            nxt = m_regs;
            if (bus.wr_en) begin
                nxt[bus.wr_addr] = bus.wr_result[15:8];
                nxt[(int'(bus.wr_addr) + 1) % D] = bus.wr_result[7:0];
            end
            if (bus.rd_en) begin
                m_a = nxt[bus.rd_addr_a];
                m_b = nxt[bus.rd_addr_b];
            end
            m_rdv = bus.rd_en;
            m_regs = nxt;
        end
    endtask

    // scoreboard compare on the falling edge
    always @(negedge clock) begin
        if (check_en) begin
            cmp("a", bus.a, m_a);
            cmp("b", bus.b, m_b);
            cmp("rd_valid", bus.rd_valid, m_rdv);
            cmp("running", bus.running, m_run);
            cmp("state_dbg", bus.state_dbg, m_run);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle();
        reset          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr_a  = '0;
        bus.rd_addr_b  = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_result  = '0;
    endtask

    task automatic load(input logic [AW-1:0] addr, input logic [W-1:0] data, input logic last);
        idle();
        bus.load_valid = 1'b1; bus.load_addr = addr; bus.load_data = data; bus.load_last = last;
        step();
        idle();
    endtask

    task automatic rd(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        idle();
        bus.rd_en = 1'b1; bus.rd_addr_a = ra; bus.rd_addr_b = rb;
        step();
        idle();
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [15:0] res);
        idle();
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_result = res;
        step();
        idle();
    endtask

    task automatic rand_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            bus.load_valid = $urandom_range(0, 1) == 1;
            bus.load_last  = ($urandom_range(0, 7) == 0);
            bus.load_addr  = AW'($urandom_range(0, D - 1));
            bus.load_data  = W'($urandom);
            bus.rd_en      = $urandom_range(0, 2) != 0;
            bus.rd_addr_a  = AW'($urandom_range(0, D - 1));
            bus.rd_addr_b  = AW'($urandom_range(0, D - 1));
            bus.wr_en      = $urandom_range(0, 1) == 1;
            bus.wr_addr    = AW'($urandom_range(0, D - 1));
            bus.wr_result  = 16'($urandom);
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        check_en = 1'b1;
        step();
        idle();
        cmp("reset_a", bus.a, 8'h00);
        cmp("reset_b", bus.b, 8'h00);
        cmp("reset_rd_valid", bus.rd_valid, 1'b0);
        cmp("reset_running", bus.running, 1'b0);

        // LOAD-state gating: writes and reads ignored
        wr(3'd5, 16'h7777);
        rd(3'd5, 3'd6);
        cmp("load_rd_valid", bus.rd_valid, 1'b0);
        cmp("load_a_hold", bus.a, 8'h00);

        load(3'd1, 8'h12, 1'b0);
        cmp("still_load", bus.running, 1'b0);
        load(3'd2, 8'h34, 1'b1);
        cmp("running_after_last", bus.running, 1'b1);

        rd(3'd1, 3'd2);
        cmp("t1_a", bus.a, 8'h12);
        cmp("t1_b", bus.b, 8'h34);
        cmp("t1_rd_valid", bus.rd_valid, 1'b1);
        step();
        cmp("idle_rd_valid", bus.rd_valid, 1'b0);
        cmp("idle_a_hold", bus.a, 8'h12);

        rd(3'd5, 3'd6);
        cmp("load_wr_ignored_a", bus.a, 8'h00);
        cmp("load_wr_ignored_b", bus.b, 8'h00);

        wr(3'd3, 16'hABCD);
        rd(3'd3, 3'd4);
        cmp("t2_a", bus.a, 8'hAB);
        cmp("t2_b", bus.b, 8'hCD);

        wr(3'd7, 16'h1122);
        rd(3'd7, 3'd0);
        cmp("wrap_a", bus.a, 8'h11);
        cmp("wrap_b", bus.b, 8'h22);

        // bypass: write and read in the same cycle
        bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_result = 16'h5566;
        bus.rd_en = 1'b1; bus.rd_addr_a = 3'd5; bus.rd_addr_b = 3'd6;
        step();
        idle();
        cmp("bypass_a", bus.a, 8'h55);
        cmp("bypass_b", bus.b, 8'h66);

        load(3'd1, 8'hFF, 1'b1);
        rd(3'd1, 3'd1);
        cmp("run_load_ignored_a", bus.a, 8'h12);
        cmp("run_load_ignored_b", bus.b, 8'h12);

        rand_phase(200);

        // reset with a write in flight
        if (!bus.running) load(3'd0, 8'h01, 1'b1);
        reset = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_result = 16'hDEAD;
        bus.rd_en = 1'b1; bus.rd_addr_a = 3'd2; bus.rd_addr_b = 3'd3;
        step();
        idle();
        cmp("rst_a", bus.a, 8'h00);
        cmp("rst_b", bus.b, 8'h00);
        cmp("rst_rd_valid", bus.rd_valid, 1'b0);
        cmp("rst_running", bus.running, 1'b0);
        load(3'd0, 8'h5A, 1'b1);
        rd(3'd2, 3'd3);
        cmp("rst_reg2", bus.a, 8'h00);
        cmp("rst_reg3", bus.b, 8'h00);
        rd(3'd0, 3'd7);
        cmp("reload_reg0", bus.a, 8'h5A);
        cmp("rst_reg7", bus.b, 8'h00);

        rand_phase(600);

        @(negedge clock);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
